alu_issue_ctrl: RTL

//  Multi-cycle decode/issue controller that drives the ALU: accepts one RV32I instruction per

---
 rtl/alu_issue_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle decode/issue controller for the rv32i_sc ALU: decodes one RV32I instruction,
// holds ALU controls stable for ISSUE_CYCLES, then resolves branches from zero/res_last_bit.
module alu_issue_ctrl #(
  parameter int XLEN         = 32,
  parameter int ISSUE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [3:0]      alu_ctrl,
  output logic            alu_src,
  output logic [XLEN-1:0] sign_ext,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            alu_op_valid,
  input  logic            zero,
  input  logic            res_last_bit,
  output logic            reg_write,
  output logic            branch_taken,
  output logic            illegal,
  output logic            done
);

  // ALU opcodes, matching the rv32i_control.vh macro values
  localparam logic [3:0] ALU_ADD       = 4'd0;
  localparam logic [3:0] ALU_SUBTRACT  = 4'd1;
  localparam logic [3:0] ALU_AND       = 4'd2;
  localparam logic [3:0] ALU_OR        = 4'd3;
  localparam logic [3:0] ALU_XOR       = 4'd4;
  localparam logic [3:0] ALU_SLTI_CMP  = 4'd5;
  localparam logic [3:0] ALU_SLTIU_CMP = 4'd6;
  localparam logic [3:0] ALU_SLL       = 4'd7;
  localparam logic [3:0] ALU_SRL       = 4'd8;
  localparam logic [3:0] ALU_SRA       = 4'd9;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ISSUE, S_RESOLVE} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  logic        dec_phase_q;
  logic [3:0]  cnt_q;
  logic        reg_write_q, illegal_q, taken_q;
  logic        is_branch_q, br_use_lsb_q, br_inv_q;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [3:0]      f3_ctrl, d_alu_ctrl;
  logic [XLEN-1:0] d_imm;
  logic            d_alu_src, d_reg_write, d_illegal, d_branch;
  logic            accept, last_issue;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];
  assign imm_i  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                   instr_q[11:8], 1'b0};

  assign accept     = instr_valid && (state_q == S_IDLE);
  assign last_issue = (state_q == S_ISSUE) && (cnt_q == 4'd1);

  // NOTE: every variable written in a combinational block gets a default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    f3_ctrl     = ALU_ADD;
    d_alu_ctrl  = ALU_ADD;
    d_alu_src   = 1'b0;
    d_imm       = '0;
    d_reg_write = 1'b0;
    d_illegal   = 1'b0;
    d_branch    = 1'b0;

    case (funct3)
      3'b000:  f3_ctrl = ALU_ADD;
      3'b001:  f3_ctrl = ALU_SLL;
      3'b010:  f3_ctrl = ALU_SLTI_CMP;
      3'b011:  f3_ctrl = ALU_SLTIU_CMP;
      3'b100:  f3_ctrl = ALU_XOR;
      3'b101:  f3_ctrl = instr_q[30] ? ALU_SRA : ALU_SRL;
      3'b110:  f3_ctrl = ALU_OR;
      default: f3_ctrl = ALU_AND;
    endcase

    case (opcode)
      OPC_OP_IMM: begin
        d_alu_src   = 1'b1;
        d_imm       = imm_i;
        d_reg_write = 1'b1;
        d_alu_ctrl  = f3_ctrl;
        // Shift-immediates reuse funct7 as an encoding field; only bit 30 may be set.
        if (funct3 == 3'b001 && funct7 != 7'h00)                   d_illegal = 1'b1;
        if (funct3 == 3'b101 && (funct7 & 7'b1011111) != 7'h00)    d_illegal = 1'b1;
      end
      OPC_OP: begin
        d_reg_write = 1'b1;
        d_alu_ctrl  = (funct3 == 3'b000 && instr_q[30]) ? ALU_SUBTRACT : f3_ctrl;
        if (!(funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))))
          d_illegal = 1'b1;
      end
      OPC_LOAD: begin
        d_alu_src   = 1'b1;
        d_imm       = imm_i;
        d_reg_write = 1'b1;
      end
      OPC_STORE: begin
        d_alu_src = 1'b1;
        d_imm     = imm_s;
      end
      OPC_BRANCH: begin
        d_imm    = imm_b;
        d_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: d_alu_ctrl = ALU_SUBTRACT;
          3'b100, 3'b101: d_alu_ctrl = ALU_SLTI_CMP;
          3'b110, 3'b111: d_alu_ctrl = ALU_SLTIU_CMP;
          default:        d_illegal  = 1'b1;
        endcase
      end
      default: d_illegal = 1'b1;
    endcase

    if (d_illegal) begin
      d_reg_write = 1'b0;
      d_branch    = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_DECODE;
      S_DECODE:  if (dec_phase_q) state_d = illegal_q ? S_RESOLVE : S_ISSUE;
      S_ISSUE:   if (last_issue) state_d = S_RESOLVE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // DECODE is two cycles: fields are registered in the first, and the regfile reads the
  // presented addresses in the second so operands are settled when ISSUE begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q      <= '0;
      dec_phase_q  <= 1'b0;
      cnt_q        <= '0;
      alu_ctrl     <= ALU_ADD;
      alu_src      <= 1'b0;
      sign_ext     <= '0;
      rs1_addr     <= '0;
      rs2_addr     <= '0;
      rd_addr      <= '0;
      reg_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
      taken_q      <= 1'b0;
      is_branch_q  <= 1'b0;
      br_use_lsb_q <= 1'b0;
      br_inv_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            instr_q     <= instr;
            dec_phase_q <= 1'b0;
          end
        end
        S_DECODE: begin
          dec_phase_q <= 1'b1;
          if (!dec_phase_q) begin
            alu_ctrl     <= d_alu_ctrl;
            alu_src      <= d_alu_src;
            sign_ext     <= d_imm;
            rs1_addr     <= instr_q[19:15];
            rs2_addr     <= instr_q[24:20];
            rd_addr      <= instr_q[11:7];
            reg_write_q  <= d_reg_write;
            illegal_q    <= d_illegal;
            is_branch_q  <= d_branch;
            br_use_lsb_q <= funct3[2];
            br_inv_q     <= funct3[0];
            taken_q      <= 1'b0;
          end else begin
            cnt_q <= 4'(ISSUE_CYCLES);
          end
        end
        S_ISSUE: begin
          cnt_q <= cnt_q - 4'd1;
          if (last_issue)
            taken_q <= is_branch_q & ((br_use_lsb_q ? res_last_bit : zero) ^ br_inv_q);
        end
        default: ;
      endcase
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign alu_op_valid = (state_q == S_ISSUE);
  assign done         = (state_q == S_RESOLVE);
  assign reg_write    = done & reg_write_q;
  assign illegal      = done & illegal_q;
  assign branch_taken = done & taken_q;

endmodule
